// File: rtl/dmem_store_buffer_if.sv
// Word-wide data-memory bus with a req/ack handshake.
// The store buffer is the master; the slow memory is the slave.
interface dmem_store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core's data port and a slow req/ack data memory:
// queues stores, drains them in the background, forwards them to loads.
//
// state   | meaning
// IDLE    | no memory transaction; drain or start a load miss
// WR_WAIT | head store on the bus, waiting for mem_ack
// RD_WAIT | load miss on the bus, waiting for mem_ack
// RD_DONE | read data latched and returned to the core this cycle
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [AW-1:0]       Adr,
    input  logic [DW-1:0]       WriteData,
    output logic [DW-1:0]       ReadData,
    output logic                Stall,
    dmem_store_buffer_if.master mem
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_DONE} state_t;

    state_t          state;
    logic [AW-3:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            req_q, we_q;
    logic [AW-1:0]   maddr_q;
    logic [DW-1:0]   wdata_q, rdata_q;

    logic            push, pop, ld, hit;
    logic [DW-1:0]   hit_data;
    logic [PW-1:0]   idx;
    logic            adr_unused;

    assign adr_unused = ^Adr[1:0];

    assign push = MemWrite && (count < CW'(DEPTH));
    assign pop  = (state == WR_WAIT) && mem.mem_ack;
    assign ld   = MemRead && !MemWrite;

    // Oldest-to-newest scan so the last match is the newest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (addr_q[idx] == Adr[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_comb begin
        Stall = (MemWrite && !push) || (ld && !hit && (state != RD_DONE));
        if (state == RD_DONE)
            ReadData = rdata_q;
        else if (hit)
            ReadData = hit_data;
        else
            ReadData = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= Adr[AW-1:2];
            data_q[tail] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= WR_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        maddr_q <= {addr_q[head], 2'b00};
                        wdata_q <= data_q[head];
                    end else if (ld && !hit) begin
                        state   <= RD_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        maddr_q <= {Adr[AW-1:2], 2'b00};
                    end
                end
                WR_WAIT: begin
                    if (mem.mem_ack) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem.mem_ack) begin
                        state   <= RD_DONE;
                        req_q   <= 1'b0;
                        rdata_q <= mem.mem_rdata;
                    end
                end
                RD_DONE: begin
                    if (count != '0) begin
                        state   <= WR_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        maddr_q <= {addr_q[head], 2'b00};
                        wdata_q <= data_q[head];
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the single-cycle datapath, between its data-side outputs (ALUResult as address, WriteData, MemWrite/MemRead) and a slow word-wide data memory that uses a req/ack handshake.
- Buffers stores in a FIFO and drains them to memory in the background.
- Forwards the newest matching buffered store data to loads.
- Stalls the core while a load must wait for memory, or when a store arrives and the buffer is full.

Parameters:
- DEPTH, 4, number of store-buffer entries (power of two, ≥2).
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- MemWrite  input  1  store request from the core
- MemRead  input  1  load request from the core
- Adr  input  AW  byte address from the core; bits [1:0] are ignored
- WriteData  input  DW  store data
- ReadData  output  DW  load data to the core
- Stall  output  1  core must hold PC and registers this cycle
- mem_req  output  1  memory request; registered
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  AW  word-aligned address; [1:0] = 0
- mem_wdata  output  DW  write data
- mem_ack  input  1  memory completion; ignored when mem_req = 0
- mem_rdata  input  DW  read data; valid with mem_ack on a read

Behaviour:
- Reset:
  - FIFO emptied (count = 0, head = tail = 0); state = IDLE.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, latched read data = 0.
  - Outputs the cycle after reset: Stall = 0 (with no request pending), ReadData = 0.
  - Reset mid-transaction abandons it; mem_req is low the next cycle.
- FSM states: IDLE, WR_WAIT, RD_WAIT, RD_DONE. mem_req = 1 exactly in WR_WAIT and RD_WAIT.
- Transitions out of IDLE:
  - count > 0 → WR_WAIT. Drain has priority over reads; head entry loads into mem_addr/mem_wdata, mem_we = 1.
  - Otherwise, MemRead and load miss → RD_WAIT; mem_addr = {Adr[AW-1:2], 2'b00}, mem_we = 0.
- WR_WAIT:
  - Hold address and data stable until mem_ack.
  - On mem_ack, pop the head and go to IDLE.
  - Minimum 2 cycles per drained store.
- RD_WAIT: on mem_ack, latch mem_rdata and go to RD_DONE.
- RD_DONE:
  - ReadData = latched data; Stall = 0.
  - Next state is IDLE, or WR_WAIT if count > 0.
- Store accept (combinational):
  - Accepted when MemWrite && count < DEPTH; pushed at the tail at the clock edge.
  - When full: Stall = 1, no push; retried every cycle.
- Push and pop in the same cycle are allowed; count is unchanged.
  - A full FIFO popping this cycle still refuses the push (Stall = 1); it accepts next cycle.
- MemWrite && MemRead together: treated as a store only.
- Load hit (combinational compare of word address [AW-1:2] against all valid entries):
  - ReadData = data of the newest matching entry; Stall = 0; no memory access.
  - Forwarding still applies while the matching entry is in flight in WR_WAIT. The entry stays valid until ack.
- Load miss:
  - Stall = 1 in every cycle from the request until RD_DONE.
  - If the buffer is non-empty, it fully drains first (preserves ordering), then the read issues.
- ReadData when no hit and not in RD_DONE: latched read data (don't-care to the core).
- Repeated stores to the same address keep separate entries and all drain in order.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Test Plan:
- Reset, then idle 5 cycles:
  - mem_req = 0, Stall = 0, ReadData = 0.
  - MemRead/MemWrite held low; mem_ack pulsed high must be ignored.
- Store 0x100←0xDEADBEEF, next cycle load 0x100 (mem_ack held off):
  - Load returns 0xDEADBEEF with Stall = 0 and no read request.
  - Then store 0x100←0x11111111; load 0x102 returns 0x11111111 (newest match).
- DEPTH+1 back-to-back stores, mem_ack held low:
  - Stores 1–4 accepted.
  - Store 5 sees Stall = 1 until the first ack pops the head; accepted the cycle after.
- Drain with ack 3 cycles after mem_req rises:
  - mem_addr/mem_wdata stable throughout.
  - Entries appear on the bus in push order; count returns to 0.
- Load miss 0x200, buffer empty, memory acks with 0xCAFEF00D after 2 req cycles:
  - Stall = 1 for 3 cycles (IDLE + 2×RD_WAIT).
  - RD_DONE cycle: ReadData = 0xCAFEF00D, Stall = 0.
- Load miss with 2 buffered stores (to other addresses), then reset asserted during the read's RD_WAIT:
  - Both writes complete before mem_we = 0 is seen.
  - After reset: mem_req = 0 next cycle, count = 0, Stall = 0.
